bit_serial_min3_tx: RTL and testbench

//  Transmit side of the bit-serial three-way minimum datapath.
//  - Accepts three parallel words per transaction and drives them out MSB-first, one bit per beat, on three serial lanes.
//  - On the same beat, drives the corresponding bit of the minimum of the three words, computed on the fly by candidate elimination.
//  - No word-wide compare; no stored result word.
//  - Feeds bit-serial consumers. Reports the winning operand when the last bit is sent.

---
 rtl/bsm_pkg.sv | 23 ++
 rtl/bsm_lane.sv | 29 ++
 rtl/bit_serial_min3_tx.sv | 151 +++++++++++++++
 tb/tb_bit_serial_min3_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsm_pkg.sv
// Shared types and helpers for the bit-serial three-way minimum transmitter.
// Lane index order everywhere is bit0=A, bit1=B, bit2=C.
package bsm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bsm_state_e;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Lowest surviving candidate wins, so equal minima resolve A over B over C.
  function automatic logic [1:0] first_alive(input logic [2:0] alive);
    logic [1:0] sel;
    sel = SEL_C;
    if (alive[1]) sel = SEL_B;
    if (alive[0]) sel = SEL_A;
    return sel;
  endfunction

endpackage

// File: rtl/bsm_lane.sv
// One serial operand lane: parallel load, shift left on enable, MSB exposed.
// Zeros are shifted in, so a fully drained lane reads as 0.
module bsm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  // A load has priority so a back-to-back reload on the final beat wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/bit_serial_min3_tx.sv
// Bit-serial transmitter for three operands plus their running minimum,
// found MSB-first by eliminating candidates that show a 1 where the minimum has a 0.
module bit_serial_min3_tx
  import bsm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_c,
  output logic             ser_min,
  output logic             ser_first,
  output logic             ser_last,
  output logic [1:0]       min_sel,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  bsm_state_e r_state;
  bsm_state_e w_state_next;

  logic [CW-1:0] r_count;
  logic [2:0]    r_alive;
  logic [1:0]    r_min_sel;
  logic          r_done;

  logic          w_msb_a;
  logic          w_msb_b;
  logic          w_msb_c;
  logic [2:0]    w_bits;
  logic [2:0]    w_alive_next;
  logic          w_in_shift;
  logic          w_min_bit;
  logic          w_xfer;
  logic          w_last_xfer;
  logic          w_accept;

  bsm_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_xfer),
    .i_data  (a),
    .o_msb   (w_msb_a)
  );

  bsm_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_xfer),
    .i_data  (b),
    .o_msb   (w_msb_b)
  );

  bsm_lane #(.WIDTH(WIDTH)) u_lane_c (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_xfer),
    .i_data  (c),
    .o_msb   (w_msb_c)
  );

  assign w_in_shift  = (r_state == SHIFT);
  assign w_bits      = {w_msb_c, w_msb_b, w_msb_a};
  assign w_xfer      = w_in_shift & ser_ready;
  assign w_last_xfer = w_xfer & (r_count == '0);
  assign w_accept    = in_valid & in_ready;

  // Minimum bit is 1 only if every live candidate shows 1; dead lanes are masked high.
  assign w_min_bit    = &(w_bits | ~r_alive);
  assign w_alive_next = w_min_bit ? r_alive : (r_alive & ~w_bits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    ser_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready  = 1'b1;
        if (in_valid) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        in_ready  = w_last_xfer;
        if (w_last_xfer && !in_valid) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counter and elimination mask advance only on accepted beats, so stalls hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_alive <= 3'b111;
    end else if (w_accept) begin
      r_count <= CNT_MAX;
      r_alive <= 3'b111;
    end else if (w_xfer) begin
      r_count <= r_count - CW'(1);
      r_alive <= w_alive_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_sel <= SEL_A;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last_xfer;
      if (w_last_xfer) begin
        r_min_sel <= first_alive(w_alive_next);
      end
    end
  end

  assign ser_a     = w_in_shift & w_msb_a;
  assign ser_b     = w_in_shift & w_msb_b;
  assign ser_c     = w_in_shift & w_msb_c;
  assign ser_min   = w_in_shift & w_min_bit;
  assign ser_first = w_in_shift & (r_count == CNT_MAX);
  assign ser_last  = w_in_shift & (r_count == '0);
  assign min_sel   = r_min_sel;
  assign done      = r_done;

endmodule

// File: tb/tb_bit_serial_min3_tx.sv
// Self-checking bench: a word-level reference model of the serial minimum transmitter,
// a per-cycle compare process, directed scenarios with literal expectations, and random traffic.
module tb_bit_serial_min3_tx;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_a;
  logic         ser_b;
  logic         ser_c;
  logic         ser_min;
  logic         ser_first;
  logic         ser_last;
  logic [1:0]   min_sel;
  logic         done;

  int nCompared   = 0;
  int nMismatched = 0;

  bit_serial_min3_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_c     (ser_c),
    .ser_min   (ser_min),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .min_sel   (min_sel),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] winnerOf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] m;
    logic [1:0]   idx;
    m = x; idx = 2'd0;
    if (y < m) begin m = y; idx = 2'd1; end
    if (z < m) begin m = z; idx = 2'd2; end
    return idx;
  endfunction

  // Reference model: the word currently being sent and which bit index is on the wire.
  logic [W-1:0] mA, mB, mC, mMin;
  int           mBeat;
  bit           mActive;
  bit           mDone;
  logic [1:0]   mSel;
  bit           mXfer, mLastX, mReady;

  assign mMin   = (mA < mB) ? ((mA < mC) ? mA : mC) : ((mB < mC) ? mB : mC);
  assign mXfer  = mActive && ser_ready;
  assign mLastX = mXfer && (mBeat == 0);
  assign mReady = !mActive || mLastX;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0;
      mDone   <= 1'b0;
      mSel    <= 2'd0;
      mBeat   <= 0;
    end else begin
      mDone <= mLastX;
      if (mLastX) mSel <= winnerOf(mA, mB, mC);
      if (in_valid && mReady) begin
        mA <= a; mB <= b; mC <= c;
        mBeat   <= W - 1;
        mActive <= 1'b1;
      end else if (mXfer) begin
        if (mBeat == 0) mActive <= 1'b0;
        else            mBeat   <= mBeat - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready",  32'(in_ready),  32'(mReady));
      checkOutput("ser_valid", 32'(ser_valid), 32'(mActive));
      checkOutput("done",      32'(done),      32'(mDone));
      checkOutput("min_sel",   32'(min_sel),   32'(mSel));
      if (mActive) begin
        checkOutput("ser_a",     32'(ser_a),     32'(mA[mBeat]));
        checkOutput("ser_b",     32'(ser_b),     32'(mB[mBeat]));
        checkOutput("ser_c",     32'(ser_c),     32'(mC[mBeat]));
        checkOutput("ser_min",   32'(ser_min),   32'(mMin[mBeat]));
        checkOutput("ser_first", 32'(ser_first), 32'(mBeat == W - 1));
        checkOutput("ser_last",  32'(ser_last),  32'(mBeat == 0));
      end
    end
  end

  // Present one triple, stream it with a ready pattern (0=always, 1=1,0,0 repeating, 2=random).
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                               input int mode, output logic [W-1:0] stream, output int xfers,
                               output bit doneSeen);
    int guard;
    bit acc;
    bit lastBeat;
    stream = '0; xfers = 0; doneSeen = 0;
    a = ta; b = tb; c = tc; in_valid = 1'b1; ser_ready = 1'b1;
    guard = 0; acc = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    guard = 0;
    lastBeat = 0;
    while (!lastBeat && guard < 200) begin
      case (mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = (guard % 3 == 0);
        default: ser_ready = 1'($urandom % 2);
      endcase
      @(negedge clk);
      if (ser_valid && ser_ready) begin
        stream = {stream[W-2:0], ser_min};
        xfers++;
        lastBeat = ser_last;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (!lastBeat) checkOutput("beat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    doneSeen = done;
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rndOperand();
    logic [W-1:0] pick;
    if ($urandom % 2 == 0) begin
      case ($urandom % 4)
        0: pick = 8'd0;
        1: pick = 8'd5;
        2: pick = 8'd128;
        default: pick = 8'hFF;
      endcase
    end else begin
      pick = W'($urandom);
    end
    return pick;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] stream;
    int           xfers;
    bit           doneSeen;
    int           run, d1, d2;
    bit           inRun, acc;

    rst_n = 1'b0; in_valid = 1'b0; ser_ready = 1'b0;
    a = '0; b = '0; c = '0;
    #1;
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("reset_done",      32'(done),      32'd0);
    checkOutput("reset_min_sel",   32'(min_sel),   32'd0);
    checkOutput("reset_ser_min",   32'(ser_min),   32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed: 33/36/43");
    applyStimulus(8'd33, 8'd36, 8'd43, 0, stream, xfers, doneSeen);
    checkOutput("t1_stream",  32'(stream),   32'd33);
    checkOutput("t1_xfers",   32'(xfers),    32'd8);
    checkOutput("t1_done",    32'(doneSeen), 32'd1);
    checkOutput("t1_min_sel", 32'(min_sel),  32'd0);

    $display("[TB] directed: 9/5/5 tie");
    applyStimulus(8'd9, 8'd5, 8'd5, 0, stream, xfers, doneSeen);
    checkOutput("t2_stream",  32'(stream),  32'd5);
    checkOutput("t2_min_sel", 32'(min_sel), 32'd1);

    $display("[TB] directed: all FF");
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 0, stream, xfers, doneSeen);
    checkOutput("t3_stream",  32'(stream),  32'hFF);
    checkOutput("t3_min_sel", 32'(min_sel), 32'd0);

    $display("[TB] directed: 200/7/100 with stalls");
    applyStimulus(8'd200, 8'd7, 8'd100, 1, stream, xfers, doneSeen);
    checkOutput("t4_stream",  32'(stream),   32'd7);
    checkOutput("t4_xfers",   32'(xfers),    32'd8);
    checkOutput("t4_done",    32'(doneSeen), 32'd1);
    checkOutput("t4_min_sel", 32'(min_sel),  32'd1);

    $display("[TB] directed: back-to-back triples");
    a = 8'd33; b = 8'd36; c = 8'd43; in_valid = 1'b1; ser_ready = 1'b1;
    acc = 0;
    for (int g = 0; g < 50 && !acc; g++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    a = 8'd50; b = 8'd20; c = 8'd30;
    run = 0; inRun = 1; d1 = -1; d2 = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (ser_valid && inRun) run++;
      else inRun = 0;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    checkOutput("t5_valid_run",  32'(run),     32'd16);
    checkOutput("t5_done1",      32'(d1),      32'd8);
    checkOutput("t5_done_gap",   32'(d2 - d1), 32'd8);
    checkOutput("t5_min_sel",    32'(min_sel), 32'd1);

    $display("[TB] directed: reset mid-transaction");
    a = 8'd33; b = 8'd36; c = 8'd43; in_valid = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("t6_in_ready",  32'(in_ready),  32'd1);
    checkOutput("t6_min_sel",   32'(min_sel),   32'd0);
    checkOutput("t6_ser_first", 32'(ser_first), 32'd0);
    checkOutput("t6_ser_a",     32'(ser_a),     32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t6_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(8'd33, 8'd36, 8'd43, 0, stream, xfers, doneSeen);
    checkOutput("t6_restream", 32'(stream), 32'd33);
    checkOutput("t6_done",     32'(doneSeen), 32'd1);

    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom % 3 != 0);
      a = rndOperand(); b = rndOperand(); c = rndOperand();
      ser_ready = ($urandom % 4 != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ser_ready = 1'b1;
    repeat (3 * W) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("drain_idle", 32'(ser_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
